// File: rtl/music_pkg.sv
// Shared note-word layout and scheduler state encoding for the note datapath.
// Word: [15] rest flag, [14:9] note, [8:3] duration/beats, [2:1] stereo, [0] unused.
package music_pkg;

  localparam int WORD_W   = 16;
  localparam int REST_BIT = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;
  localparam int ST_MSB   = 2;
  localparam int ST_LSB   = 1;

  localparam int NOTE_W = NOTE_MSB - NOTE_LSB + 1;
  localparam int DUR_W  = DUR_MSB - DUR_LSB + 1;
  localparam int ST_W   = ST_MSB - ST_LSB + 1;

  // DISP is the cycle the load strobe is on the bus; REQ only holds a
  // request that could not go out because play was low.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_ALLOC = 3'd3,
    S_DISP  = 3'd4,
    S_REST  = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic              rest;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
    logic [ST_W-1:0]   st;
  } note_word_t;

  function automatic note_word_t decode_word(input logic [WORD_W-1:1] w);
    note_word_t r;
    r.rest = w[REST_BIT];
    r.note = w[NOTE_MSB:NOTE_LSB];
    r.dur  = w[DUR_MSB:DUR_LSB];
    r.st   = w[ST_MSB:ST_LSB];
    return r;
  endfunction

endpackage

// File: rtl/first_free_picker.sv
// Picks the lowest-index free voice as a one-hot grant; any_free_o flags
// that at least one voice can take a note.
module first_free_picker #(
  parameter int N = 3
) (
  input  logic [N-1:0] free_i,
  output logic [N-1:0] grant_o,
  output logic         any_free_o
);

  logic seen;

  always_comb begin
    grant_o = '0;
    seen    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (free_i[i] && !seen) begin
        grant_o[i] = 1'b1;
        seen       = 1'b1;
      end
    end
  end

  assign any_free_o = |free_i;

endmodule

// File: rtl/voice_scheduler.sv
// Fetches note words, dispatches notes to the lowest free voice over a shared
// load bus, times rests in beats and stalls fetching while all voices are busy.
module voice_scheduler
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 3
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  play_i,
  input  logic                  beat_i,
  input  logic [WORD_W-1:0]     note_in_i,
  input  logic                  note_valid_i,
  output logic                  note_req_o,
  input  logic [NUM_VOICES-1:0] voice_done_i,
  output logic [NUM_VOICES-1:0] voice_load_o,
  output logic [NOTE_W-1:0]     voice_note_o,
  output logic [DUR_W-1:0]      voice_duration_o,
  output logic [ST_W-1:0]       voice_stereo_o,
  output logic [NUM_VOICES-1:0] voice_busy_o,
  output logic                  advance_time_o
);

  sched_state_e state_q, state_d;
  note_word_t   word_q, word_d, cur_word;

  logic [DUR_W-1:0]      rest_cnt_q, rest_cnt_d;
  logic [NUM_VOICES-1:0] busy_q, busy_d;
  logic [NUM_VOICES-1:0] load_q, load_d;
  logic [NUM_VOICES-1:0] free_vec, grant;
  logic                  any_free;
  logic                  note_req_q, note_req_d;
  logic                  adv_q;
  logic                  go_req;
  logic [NOTE_W-1:0]     bus_note_q, bus_note_d;
  logic [DUR_W-1:0]      bus_dur_q, bus_dur_d;
  logic [ST_W-1:0]       bus_st_q, bus_st_d;
  logic                  unused_bit0;

  assign unused_bit0 = note_in_i[0];

  // A done frees its voice for dispatch in the same cycle, except on the
  // cycle that voice is being loaded: the new note keeps it busy.
  assign free_vec = ~(busy_q & ~(voice_done_i & ~load_q));

  first_free_picker #(.N(NUM_VOICES)) u_pick (
    .free_i     (free_vec),
    .grant_o    (grant),
    .any_free_o (any_free)
  );

  // In WAIT the word is taken straight off the input so a free voice is
  // loaded the cycle after note_valid; a stalled ALLOC uses the latched word.
  assign cur_word = (state_q == S_WAIT) ? decode_word(note_in_i[WORD_W-1:1]) : word_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    rest_cnt_d = rest_cnt_q;
    load_d     = '0;
    note_req_d = 1'b0;
    bus_note_d = bus_note_q;
    bus_dur_d  = bus_dur_q;
    bus_st_d   = bus_st_q;
    go_req     = 1'b0;

    case (state_q)
      S_IDLE: if (play_i) go_req = 1'b1;
      S_REQ:  go_req = 1'b1;
      S_WAIT: begin
        if (note_valid_i) begin
          word_d = cur_word;
          if (cur_word.dur == '0) begin
            go_req = 1'b1;
          end else if (cur_word.rest) begin
            rest_cnt_d = cur_word.dur;
            state_d    = S_REST;
          end else begin
            state_d = S_ALLOC;
          end
        end
      end
      S_ALLOC: ;
      S_DISP:  go_req = 1'b1;
      S_REST: begin
        if (play_i && beat_i) begin
          rest_cnt_d = rest_cnt_q - DUR_W'(1);
          if (rest_cnt_q == DUR_W'(1)) go_req = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ALLOC && play_i && any_free) begin
      load_d     = grant;
      bus_note_d = cur_word.note;
      bus_dur_d  = cur_word.dur;
      bus_st_d   = cur_word.st;
      state_d    = S_DISP;
    end

    // A request that cannot issue while paused parks in REQ.
    if (go_req) begin
      if (play_i) begin
        note_req_d = 1'b1;
        state_d    = S_WAIT;
      end else begin
        state_d = S_REQ;
      end
    end

    busy_d = ~free_vec | load_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      rest_cnt_q <= '0;
      busy_q     <= '0;
      load_q     <= '0;
      note_req_q <= 1'b0;
      adv_q      <= 1'b0;
      bus_note_q <= '0;
      bus_dur_q  <= '0;
      bus_st_q   <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      rest_cnt_q <= rest_cnt_d;
      busy_q     <= busy_d;
      load_q     <= load_d;
      note_req_q <= note_req_d;
      adv_q      <= play_i;
      bus_note_q <= bus_note_d;
      bus_dur_q  <= bus_dur_d;
      bus_st_q   <= bus_st_d;
    end
  end

  assign note_req_o       = note_req_q;
  assign voice_load_o     = load_q;
  assign voice_note_o     = bus_note_q;
  assign voice_duration_o = bus_dur_q;
  assign voice_stereo_o   = bus_st_q;
  assign voice_busy_o     = busy_q;
  assign advance_time_o   = adv_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: per-cycle vector table, directed multi-cycle
// sequences, then randomized traffic against a transaction-level model.
module tb_voice_scheduler;

  localparam int NV = 3;

  logic          clk = 1'b0;
  logic          reset, play, beat, nv, req, adv;
  logic [15:0]   word;
  logic [NV-1:0] done, load, busy;
  logic [5:0]    vnote, vdur;
  logic [1:0]    vst;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_scheduler #(.NUM_VOICES(NV)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .play_i           (play),
    .beat_i           (beat),
    .note_in_i        (word),
    .note_valid_i     (nv),
    .note_req_o       (req),
    .voice_done_i     (done),
    .voice_load_o     (load),
    .voice_note_o     (vnote),
    .voice_duration_o (vdur),
    .voice_stereo_o   (vst),
    .voice_busy_o     (busy),
    .advance_time_o   (adv)
  );

  typedef struct {
    logic          play;
    logic          nv;
    logic [15:0]   w;
    logic [NV-1:0] done;
    logic          req;
    logic [NV-1:0] load;
    logic [NV-1:0] busy;
    logic [5:0]    note;
    logic [5:0]    dur;
    logic [1:0]    st;
  } vec_t;

  vec_t tv[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n = 0;
    while (req !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (req !== 1'b1) chk("req_timeout", 32'(req), 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w);
    nv = 1'b1; word = w;
    step();
    nv = 1'b0;
  endtask

  task automatic give_word(input logic [15:0] w);
    wait_req();
    step();
    send_word(w);
  endtask

  function automatic logic [15:0] mkw(input logic [5:0] n, input logic [5:0] d, input logic [1:0] s);
    return {1'b0, n, d, s, 1'b0};
  endfunction

  function automatic logic [15:0] rand_word();
    int r = $urandom_range(0, 9);
    logic [5:0] junk = 6'($urandom);
    if (r < 2) return {1'b1, junk, 6'($urandom_range(0, 4)), 3'($urandom)};
    if (r == 2) return {1'b0, junk, 6'd0, 3'($urandom)};
    return {1'b0, junk, 6'($urandom_range(1, 63)), 3'($urandom)};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(req), 0);
    chk({tag, "_load"}, 32'(load), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_bus"}, 32'({vnote, vdur, vst}), 0);
    chk({tag, "_adv"}, 32'(adv), 0);
  endtask

  // model state for the random phase
  logic [NV-1:0] mb, ld_m, done_v;
  logic [15:0]   pend[$];
  logic [15:0]   w, p_word;
  logic          p_play, p_beat, p_nv, rest_active, waiting;
  int            exp_req_at, beats_left, resp_at, lo, nloads;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // play, nv, word, done | req, load, busy, note, dur, st (outputs one cycle later)
    tv[0]  = '{1'b1, 1'b0, 16'h0000, 3'b000, 1'b1, 3'b000, 3'b000, 6'd0,  6'd0,  2'd0};
    tv[1]  = '{1'b1, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b000, 3'b000, 6'd0,  6'd0,  2'd0};
    tv[2]  = '{1'b1, 1'b1, 16'h0A58, 3'b000, 1'b0, 3'b001, 3'b001, 6'd5,  6'd11, 2'd0};
    tv[3]  = '{1'b1, 1'b0, 16'h0000, 3'b000, 1'b1, 3'b000, 3'b001, 6'd5,  6'd11, 2'd0};
    tv[4]  = '{1'b1, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b000, 3'b001, 6'd5,  6'd11, 2'd0};
    tv[5]  = '{1'b1, 1'b1, 16'h0E02, 3'b000, 1'b1, 3'b000, 3'b001, 6'd5,  6'd11, 2'd0};
    tv[6]  = '{1'b1, 1'b0, 16'h0000, 3'b100, 1'b0, 3'b000, 3'b001, 6'd5,  6'd11, 2'd0};
    tv[7]  = '{1'b1, 1'b0, 16'h0000, 3'b001, 1'b0, 3'b000, 3'b000, 6'd5,  6'd11, 2'd0};
    tv[8]  = '{1'b1, 1'b1, 16'h8000, 3'b000, 1'b1, 3'b000, 3'b000, 6'd5,  6'd11, 2'd0};
    tv[9]  = '{1'b1, 1'b1, 16'h7E0E, 3'b000, 1'b0, 3'b001, 3'b001, 6'd63, 6'd1,  2'd3};
    tv[10] = '{1'b1, 1'b1, 16'h0A58, 3'b000, 1'b1, 3'b000, 3'b001, 6'd63, 6'd1,  2'd3};
    tv[11] = '{1'b1, 1'b0, 16'h0000, 3'b000, 1'b0, 3'b000, 3'b001, 6'd63, 6'd1,  2'd3};

    reset = 1'b1; play = 1'b0; beat = 1'b0; nv = 1'b0; word = '0; done = '0;
    step(); step();
    chk_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      play = tv[i].play; nv = tv[i].nv; word = tv[i].w; done = tv[i].done;
      step();
      chk($sformatf("t%0d_req", i),  32'(req),   32'(tv[i].req));
      chk($sformatf("t%0d_load", i), 32'(load),  32'(tv[i].load));
      chk($sformatf("t%0d_busy", i), 32'(busy),  32'(tv[i].busy));
      chk($sformatf("t%0d_bus", i),  32'({vnote, vdur, vst}), 32'({tv[i].note, tv[i].dur, tv[i].st}));
      chk($sformatf("t%0d_adv", i),  32'(adv),   32'd1);
    end
    nv = 1'b0; done = '0;

    // rest of 3 beats; the beat coinciding with the rest word is not counted
    done = 3'b001; step(); done = '0;
    nv = 1'b1; word = 16'h8018; beat = 1'b1;
    step();
    nv = 1'b0; beat = 1'b0;
    for (int b = 0; b < 3; b++) begin
      step();
      chk("rest_early_req", 32'(req), 0);
      chk("rest_load", 32'(load), 0);
      beat = 1'b1; step(); beat = 1'b0;
      chk($sformatf("rest_beat%0d_req", b), 32'(req), 32'(b == 2));
    end

    // pause mid-rest: beats while paused are ignored
    give_word(16'h8018);
    beat = 1'b1; step(); beat = 1'b0;
    play = 1'b0;
    chk("adv_before_pause", 32'(adv), 1);
    step();
    chk("adv_paused", 32'(adv), 0);
    for (int b = 0; b < 5; b++) begin
      beat = 1'b1; step(); beat = 1'b0; step();
      chk("pause_req", 32'(req), 0);
    end
    play = 1'b1;
    chk("adv_before_resume", 32'(adv), 0);
    step();
    chk("adv_resumed", 32'(adv), 1);
    beat = 1'b1; step(); beat = 1'b0;
    chk("resume_beat1_req", 32'(req), 0);
    beat = 1'b1; step(); beat = 1'b0;
    chk("resume_beat2_req", 32'(req), 1);

    // note_valid while paused in WAIT is held until play returns
    play = 1'b0; step();
    send_word(mkw(6'd9, 6'd4, 2'd2));
    for (int c = 0; c < 3; c++) begin
      chk("paused_load", 32'(load), 0);
      chk("paused_req", 32'(req), 0);
      step();
    end
    play = 1'b1; step();
    chk("unpause_load", 32'(load), 3'b001);
    chk("unpause_bus", 32'({vnote, vdur, vst}), 32'({6'd9, 6'd4, 2'd2}));
    step();
    chk("unpause_req", 32'(req), 1);

    // three back-to-back notes, a fourth stalls until a voice is freed
    done = 3'b001; step(); done = '0;
    send_word(mkw(6'd1, 6'd10, 2'd0));
    chk("bb1_load", 32'(load), 3'b001);
    give_word(mkw(6'd2, 6'd20, 2'd1));
    chk("bb2_load", 32'(load), 3'b010);
    give_word(mkw(6'd3, 6'd30, 2'd2));
    chk("bb3_load", 32'(load), 3'b100);
    chk("bb3_busy", 32'(busy), 3'b111);
    give_word(mkw(6'd4, 6'd40, 2'd3));
    for (int c = 0; c < 3; c++) begin
      chk("stall_load", 32'(load), 0);
      chk("stall_req", 32'(req), 0);
      chk("stall_busy", 32'(busy), 3'b111);
      step();
    end
    done = 3'b010; step(); done = '0;
    chk("unstall_load", 32'(load), 3'b010);
    chk("unstall_bus", 32'({vnote, vdur, vst}), 32'({6'd4, 6'd40, 2'd3}));
    done = 3'b010; step(); done = '0;
    chk("set_wins_busy", 32'(busy), 3'b111);
    chk("unstall_req", 32'(req), 1);

    // reset while stalled in ALLOC with every voice busy
    give_word(mkw(6'd5, 6'd5, 2'd1));
    step();
    chk("pre_reset_busy", 32'(busy), 3'b111);
    #1 reset = 1'b1; play = 1'b0;
    #1 chk_all_zero("rst_alloc");
    step(); reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("idle_req", 32'(req), 0);
    end
    play = 1'b1; step();
    chk("first_req", 32'(req), 1);

    // reset with a load strobe in flight
    step();
    send_word(mkw(6'd6, 6'd6, 2'd1));
    chk("inflight_load", 32'(load), 3'b001);
    #1 reset = 1'b1; play = 1'b0;
    #1 chk_all_zero("rst_inflight");
    step(); reset = 1'b0;

    // randomized traffic against a transaction-level model
    mb = '0; p_play = 1'b0; p_beat = 1'b0; p_nv = 1'b0; p_word = '0;
    rest_active = 1'b0; waiting = 1'b0; exp_req_at = 1; beats_left = 0;
    resp_at = 0; nloads = 0;
    for (int k = 0; k < 3000; k++) begin
      if (rest_active && p_play && p_beat) begin
        beats_left--;
        if (beats_left == 0) begin
          rest_active = 1'b0;
          exp_req_at  = k;
        end
      end
      if (p_nv) begin
        if (p_word[8:3] == 6'd0) exp_req_at = k;
        else if (p_word[15]) begin
          rest_active = 1'b1;
          beats_left  = int'(p_word[8:3]);
        end else pend.push_back(p_word);
      end
      chk("r_adv", 32'(adv), 32'(p_play));
      chk("r_req", 32'(req), 32'(exp_req_at == k));
      if (req === 1'b1) begin
        waiting = 1'b1;
        resp_at = k + $urandom_range(1, 4);
      end
      lo = -1;
      for (int i = NV - 1; i >= 0; i--) if (!mb[i]) lo = i;
      ld_m = '0;
      if (pend.size() > 0 && lo >= 0) begin
        w = pend.pop_front();
        ld_m[lo] = 1'b1;
        chk("r_load", 32'(load), 32'(ld_m));
        chk("r_bus", 32'({vnote, vdur, vst}), 32'({w[14:9], w[8:3], w[2:1]}));
        mb[lo] = 1'b1;
        exp_req_at = k + 1;
        nloads++;
      end else begin
        chk("r_load_idle", 32'(load), 0);
      end
      chk("r_busy", 32'(busy), 32'(mb));

      done_v = ($urandom_range(0, 3) == 0) ? NV'($urandom) : '0;
      for (int i = 0; i < NV; i++) if (done_v[i] && !ld_m[i]) mb[i] = 1'b0;
      done = done_v;
      play = 1'b1;
      beat = ($urandom_range(0, 2) == 0);
      if (waiting && k == resp_at) begin
        nv = 1'b1; word = rand_word(); waiting = 1'b0;
      end else begin
        nv = 1'b0;
      end
      p_play = play; p_beat = beat; p_nv = nv; p_word = word;
      step();
    end
    chk("r_progress", 32'(nloads > 50), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
